// File: rtl/display_scanner.sv
// Four-digit multiplexed display scanner with prescaler, per-slot guard blanking and
// frame-synchronous double-buffered value updates. Optional macro: LEADING_ZERO_BLANK_EN.
module display_scanner #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned GUARD   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    output logic [3:0]  digit,
    output logic        decimal,
    output logic [3:0]  anode,
    output logic        busy
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_MAX = cnt_t'(CLK_DIV - 1);

    cnt_t        cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [15:0] pending_q, pending_d;
    logic [3:0]  pending_dp_q, pending_dp_d;
    logic        busy_q, busy_d;
    logic [3:0]  digit_q, digit_d;
    logic        decimal_q, decimal_d;
    logic [3:0]  anode_q, anode_d;
    logic        tick;
    logic        boundary;
    logic        blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            pending_q    <= 16'h0000;
            pending_dp_q <= 4'h0;
            busy_q       <= 1'b0;
            digit_q      <= 4'h0;
            decimal_q    <= 1'b0;
            anode_q      <= 4'b1111;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            pending_dp_q <= pending_dp_d;
            busy_q       <= busy_d;
            digit_q      <= digit_d;
            decimal_q    <= decimal_d;
            anode_q      <= anode_d;
        end
    end

    // Prescaler and slot index; both freeze while enable is low.
    always_comb begin
        tick     = enable && (cnt_q == CNT_MAX);
        boundary = tick && (idx_q == 2'd3);
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        if (enable) begin
            if (tick) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
    end

    // Loads park in pending; shadow only changes on a frame boundary so a frame is never torn.
    always_comb begin
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        pending_dp_d = pending_dp_q;
        busy_d       = busy_q;
        if (boundary) begin
            if (load) begin
                shadow_d    = value;
                shadow_dp_d = dp;
            end else if (busy_q) begin
                shadow_d    = pending_q;
                shadow_dp_d = pending_dp_q;
            end
            busy_d = 1'b0;
        end else if (load) begin
            pending_d    = value;
            pending_dp_d = dp;
            busy_d       = 1'b1;
        end
    end

    // Outputs are computed from next state so they change on the same edge as idx.
    always_comb begin
        digit_d   = shadow_d[{idx_d, 2'b00} +: 4];
        decimal_d = shadow_dp_d[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx_d != 2'd0) && !shadow_dp_d[idx_d] &&
                ((shadow_d >> {idx_d, 2'b00}) == 16'h0000);
`else
        blank = 1'b0;
`endif
        if (enable && (32'(cnt_d) >= GUARD) && !blank) begin
            anode_d = ~(4'b0001 << idx_d);
        end else begin
            anode_d = 4'b1111;
        end
    end

    assign digit   = digit_q;
    assign decimal = decimal_q;
    assign anode   = anode_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner (CLK_DIV=4, GUARD=1); a small position
// model tracks cnt/idx so stimulus can be placed on slot and frame boundaries.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit;
    logic        decimal;
    logic [3:0]  anode;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_cnt   = 0;
    logic [1:0]  m_idx   = 2'd0;

    display_scanner #(
        .CLK_DIV(4),
        .GUARD  (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .load   (load),
        .value  (value),
        .dp     (dp),
        .digit  (digit),
        .decimal(decimal),
        .anode  (anode),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge; the model mirrors the intended prescaler/slot behaviour.
    task automatic step();
        if (reset) begin
            m_cnt = 0;
            m_idx = 2'd0;
        end else if (enable) begin
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_idx = m_idx + 2'd1;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Stop on the cycle whose following edge is the frame boundary.
    task automatic goto_pre_boundary();
        for (int i = 0; i < 40 && !(m_idx == 2'd3 && m_cnt == 3); i++) step();
    endtask

    // Called at cnt 0 of a slot: guard cycle, then lit cycle, then on to the next slot.
    task automatic check_slot(input string tag, input logic [3:0] exp_digit,
                              input logic exp_dec, input logic [3:0] exp_anode);
        check({tag, "_guard_anode"}, 16'(anode), 16'hF);
        check({tag, "_digit"}, 16'(digit), 16'(exp_digit));
        check({tag, "_decimal"}, 16'(decimal), 16'(exp_dec));
        step();
        check({tag, "_anode"}, 16'(anode), 16'(exp_anode));
        check({tag, "_digit_hold"}, 16'(digit), 16'(exp_digit));
        step();
        step();
        step();
    endtask

    task automatic load_now(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    logic [3:0] an2, an3, an1z;

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        load   = 1'b1;
        value  = 16'hFFFF;
        dp     = 4'hF;
        step();
        load = 1'b0;
        step();
        check("rst_anode", 16'(anode), 16'hF);
        check("rst_digit", 16'(digit), 16'h0);
        check("rst_decimal", 16'(decimal), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        reset  = 1'b0;
        enable = 1'b1;

        // Scan: 1234 with DP on position 2
        for (int i = 0; i < 5; i++) step();
        load_now(16'h1234, 4'b0100);
        check("scan_busy_set", 16'(busy), 16'h1);
        goto_pre_boundary();
        check("scan_busy_pre", 16'(busy), 16'h1);
        check("scan_old_digit", 16'(digit), 16'h0);
        step();
        check("scan_busy_clr", 16'(busy), 16'h0);
        check_slot("scan_s0", 4'h4, 1'b0, 4'b1110);
        check_slot("scan_s1", 4'h3, 1'b0, 4'b1101);
        check_slot("scan_s2", 4'h2, 1'b1, 4'b1011);
        check_slot("scan_s3", 4'h1, 1'b0, 4'b0111);

        // Pending: AAAA overwritten by BBBB before the boundary
        for (int i = 0; i < 5; i++) step();
        load_now(16'hAAAA, 4'h0);
        check("pend_busy_a", 16'(busy), 16'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("pend_no_a", 16'(digit == 4'hA), 16'h0);
        end
        load_now(16'hBBBB, 4'h0);
        check("pend_busy_b", 16'(busy), 16'h1);
        for (int i = 0; i < 40 && !(m_idx == 2'd3 && m_cnt == 3); i++) begin
            check("pend_no_a", 16'(digit == 4'hA), 16'h0);
            check("pend_busy_hold", 16'(busy), 16'h1);
            step();
        end
        step();
        check("pend_busy_clr", 16'(busy), 16'h0);
        check_slot("pend_s0", 4'hB, 1'b0, 4'b1110);
        check_slot("pend_s1", 4'hB, 1'b0, 4'b1101);
        check_slot("pend_s2", 4'hB, 1'b0, 4'b1011);
        check_slot("pend_s3", 4'hB, 1'b0, 4'b0111);

        // Boundary load goes straight to shadow
`ifdef LEADING_ZERO_BLANK_EN
        an2 = 4'b1111;
        an3 = 4'b1111;
`else
        an2 = 4'b1011;
        an3 = 4'b0111;
`endif
        goto_pre_boundary();
        load_now(16'h00F0, 4'h0);
        check("bnd_busy", 16'(busy), 16'h0);
        check_slot("bnd_s0", 4'h0, 1'b0, 4'b1110);
        check("bnd_busy_next", 16'(busy), 16'h0);
        check_slot("bnd_s1", 4'hF, 1'b0, 4'b1101);
        check_slot("bnd_s2", 4'h0, 1'b0, an2);
        check_slot("bnd_s3", 4'h0, 1'b0, an3);

        // Enable freeze mid-slot 1, with a load accepted into pending
        for (int i = 0; i < 5; i++) step();
        check("en_pre_anode", 16'(anode), 16'b1101);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) load_now(16'h5678, 4'h0);
            else step();
            check("en_off_anode", 16'(anode), 16'hF);
            check("en_off_digit", 16'(digit), 16'hF);
        end
        check("en_off_busy", 16'(busy), 16'h1);
        enable = 1'b1;
        step();
        check("en_resume_c2", 16'(anode), 16'b1101);
        step();
        check("en_resume_c3", 16'(anode), 16'b1101);
        check("en_resume_dig", 16'(digit), 16'hF);
        step();
        check("en_next_anode", 16'(anode), 16'hF);
        check("en_next_digit", 16'(digit), 16'h0);

        // Reset during slot 2 with busy set, colliding with a load
        step();
        check("rst2_busy_pre", 16'(busy), 16'h1);
        reset = 1'b1;
        load_now(16'h9999, 4'hF);
        reset = 1'b0;
        check("rst2_anode", 16'(anode), 16'hF);
        check("rst2_busy", 16'(busy), 16'h0);
        check("rst2_digit", 16'(digit), 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
        an1z = 4'b1111;
        an2  = 4'b1111;
        an3  = 4'b1111;
`else
        an1z = 4'b1101;
        an2  = 4'b1011;
        an3  = 4'b0111;
`endif
        check_slot("rst2_s0", 4'h0, 1'b0, 4'b1110);
        check_slot("rst2_s1", 4'h0, 1'b0, an1z);
        check_slot("rst2_s2", 4'h0, 1'b0, an2);
        check_slot("rst2_s3", 4'h0, 1'b0, an3);
        check("rst2_frame_busy", 16'(busy), 16'h0);
        check("rst2_frame_digit", 16'(digit), 16'h0);

        // Leading-zero scenario: 0050, then 0050 with DP on position 3
`ifdef LEADING_ZERO_BLANK_EN
        an2 = 4'b1111;
        an3 = 4'b1111;
`else
        an2 = 4'b1011;
        an3 = 4'b0111;
`endif
        goto_pre_boundary();
        load_now(16'h0050, 4'h0);
        check_slot("lz_s0", 4'h0, 1'b0, 4'b1110);
        check_slot("lz_s1", 4'h5, 1'b0, 4'b1101);
        check_slot("lz_s2", 4'h0, 1'b0, an2);
        check_slot("lz_s3", 4'h0, 1'b0, an3);
        goto_pre_boundary();
        load_now(16'h0050, 4'b1000);
        check_slot("lzdp_s0", 4'h0, 1'b0, 4'b1110);
        check_slot("lzdp_s1", 4'h5, 1'b0, 4'b1101);
        check_slot("lzdp_s2", 4'h0, 1'b0, an2);
        check_slot("lzdp_s3", 4'h0, 1'b1, 4'b0111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
